// File: rtl/seq_mul_ctrl.sv
// Two-requester round-robin front end sharing one shift-and-add unsigned multiplier.
// Optional macro SEQ_MUL_EARLY_EXIT_EN ends the CALC phase once the remaining multiplier is zero.
module seq_mul_ctrl #(
    parameter int p_width = 8
) (
    input  logic                   i_w_clk,
    input  logic                   i_w_rst_n,
    input  logic                   i_w_valid0,
    input  logic                   i_w_valid1,
    input  logic [p_width-1:0]     i_w_a0,
    input  logic [p_width-1:0]     i_w_b0,
    input  logic [p_width-1:0]     i_w_a1,
    input  logic [p_width-1:0]     i_w_b1,
    output logic                   o_w_ready0,
    output logic                   o_w_ready1,
    output logic [2*p_width-1:0]   o_w_p,
    output logic                   o_w_id,
    output logic                   o_w_valid,
    input  logic                   i_w_ready,
    output logic                   o_w_busy
);

    localparam int lp_pw = 2 * p_width;
    localparam int lp_cw = (p_width > 2) ? $clog2(p_width) : 1;
    localparam logic [lp_cw-1:0] lp_cnt_last = lp_cw'(p_width - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [lp_pw-1:0]      r_mcand;
    logic [p_width-1:0]    r_mplier;
    logic [lp_pw-1:0]      r_acc;
    logic [lp_cw-1:0]      r_count;
    logic                  r_id;
    logic                  r_last;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_xfer;
    logic [p_width-1:0]    w_sel_a;
    logic [p_width-1:0]    w_sel_b;
    logic [p_width-1:0]    w_mplier_shr;
    logic [lp_pw-1:0]      w_acc_sum;
    logic                  w_calc_last;

    // Arbitration is only live in IDLE; a tie goes to the requester not served last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == ST_IDLE) begin
            if (i_w_valid0 && i_w_valid1) begin
                w_grant0 = r_last;
                w_grant1 = ~r_last;
            end else begin
                w_grant0 = i_w_valid0;
                w_grant1 = i_w_valid1;
            end
        end
    end

    assign w_xfer  = (w_grant0 & i_w_valid0) | (w_grant1 & i_w_valid1);
    assign w_sel_a = w_grant1 ? i_w_a1 : i_w_a0;
    assign w_sel_b = w_grant1 ? i_w_b1 : i_w_b0;

    assign w_mplier_shr = r_mplier >> 1;
    assign w_acc_sum    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign w_calc_last = (r_count == lp_cnt_last) || (w_mplier_shr == '0);
`else
    assign w_calc_last = (r_count == lp_cnt_last);
`endif

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!i_w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_xfer)      w_state_nxt = ST_CALC;
            ST_CALC: if (w_calc_last) w_state_nxt = ST_DONE;
            ST_DONE: if (i_w_ready)   w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_id     <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            if (w_xfer) begin
                r_mcand  <= {{p_width{1'b0}}, w_sel_a};
                r_mplier <= w_sel_b;
                r_acc    <= '0;
                r_count  <= '0;
                r_id     <= w_grant1;
            end else if (r_state == ST_CALC) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= w_mplier_shr;
                r_count  <= r_count + lp_cw'(1);
            end
            if ((r_state == ST_DONE) && i_w_ready) begin
                r_last <= r_id;
            end
        end
    end

    assign o_w_ready0 = w_grant0;
    assign o_w_ready1 = w_grant1;
    assign o_w_valid  = (r_state == ST_DONE);
    assign o_w_p      = o_w_valid ? r_acc : '0;
    assign o_w_id     = o_w_valid & r_id;
    assign o_w_busy   = (r_state != ST_IDLE);

endmodule

// File: doc/seq_mul_ctrl.md
SEQ_MUL_CTRL -- requirements
Module: seq_mul_ctrl

Interface
REQ-001 SHALL have parameter p_width, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port i_w_clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port i_w_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_w_valid0 / i_w_valid1  input  1  requester 0 / 1 operation request.
REQ-005 SHALL have ports i_w_a0, i_w_b0, i_w_a1, i_w_b1  input  p_width  unsigned multiplicand / multiplier per requester.
REQ-006 SHALL have ports o_w_ready0 / o_w_ready1  output  1  grant; transfer = valid & ready on the same edge.
REQ-007 SHALL have port o_w_p  output  2*p_width  unsigned product.
REQ-008 SHALL have port o_w_id  output  1  requester that owns o_w_p.
REQ-009 SHALL have port o_w_valid  output  1  result available.
REQ-010 SHALL have port i_w_ready  input  1  result consumer accepts.
REQ-011 SHALL have port o_w_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; one shared shift-and-add datapath.
REQ-013 IDLE: ready asserted combinationally to one valid requester only; if both valid, grant the one not served last (round-robin); ready0/ready1 SHALL be 0 outside IDLE.
REQ-014 On transfer: latch a zero-extended to 2*p_width into multiplicand reg, b into multiplier reg, accumulator=0, count=0, id=granted index; next state CALC.
REQ-015 CALC per cycle: if multiplier LSB=1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; count += 1.
REQ-016 CALC SHALL exit to DONE after exactly p_width cycles (count reaching p_width-1 in current cycle), all p_width bits of b consumed.
REQ-017 Latency: transfer in cycle T -> CALC T+1..T+p_width -> o_w_valid=1 from T+p_width+1.
REQ-018 DONE: o_w_valid=1, o_w_p=accumulator, o_w_id held stable until i_w_ready=1; on that edge go IDLE and update last-served to o_w_id.
REQ-019 No request accepted in the DONE-handshake cycle; peak throughput one operation per p_width+2 cycles.
REQ-020 o_w_p and o_w_id SHALL read 0 while o_w_valid=0.
REQ-021 Product exact: (2^p_width-1)^2 fits 2*p_width bits; no overflow, no truncation.
REQ-022 Requester dropping valid before grant SHALL have no effect on state or arbitration.

Reset
REQ-023 i_w_rst_n low SHALL immediately force state IDLE; accumulator, multiplicand, multiplier, count, id = 0; last-served=1 (requester 0 wins first tie).
REQ-024 Reset asserted in CALC or DONE aborts the operation; o_w_valid SHALL not assert for it.
REQ-025 First transfer possible on first rising edge with i_w_rst_n high.

Configuration
REQ-026 Macro SEQ_MUL_EARLY_EXIT_EN defined: CALC SHALL also exit to DONE when the multiplier value after the current cycle's shift is 0 (minimum 1 CALC cycle, incl. b=0); product unchanged.
REQ-027 Macro undefined: CALC length is always exactly p_width cycles.

Verification (p_width=8)
REQ-028 req0 a=13 b=11 transfer at T -> o_w_valid at T+9, o_w_p=143, o_w_id=0.
REQ-029 a=255 b=255 -> o_w_p=65025; a=0 b=200 -> o_w_p=0.
REQ-030 After reset both valid (req0 a=3 b=5, req1 a=7 b=9) held -> results 15 id=0 then 63 id=1, then alternating grants.
REQ-031 i_w_ready low 5 cycles in DONE -> o_w_p, o_w_id stable, ready0/ready1=0, o_w_busy=1; i_w_ready=1 -> IDLE next cycle.
REQ-032 Reset pulse at T+4 of an operation -> o_w_valid never asserts, outputs 0; next operation a=6 b=7 -> 42.
REQ-033 a=200 b=1 -> o_w_valid at T+2 with SEQ_MUL_EARLY_EXIT_EN, T+9 without; o_w_p=200 both.
